serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//  Multi-cycle, digit-serial subtractor: diff = a - b - bin over WIDTH bits, DIGIT bits per clock.
//  Parametrised sequential successor to the 1-bit full subtractor (fs): the borrow is held in a register between digits.
//  Sits behind any control FSM that needs wide subtraction at low area; start/done handshake.
// PARAMETERS
//  WIDTH  16  operand/result width in bits; >= 1
//  DIGIT   4  bits processed per cycle; must divide WIDTH exactly (1 <= DIGIT <= WIDTH)
// PORTS
//  clk         in   1      rising-edge clock
//  rst         in   1      asynchronous, active-high reset
//  start       in   1      request; sampled only when busy=0
//  a           in   WIDTH  minuend, captured on accepted start
//  b           in   WIDTH  subtrahend, captured on accepted start
//  bin         in   1      borrow-in, captured on accepted start
//  busy        out  1      high from the cycle after acceptance until done
//  done        out  1      one-cycle pulse; difference/barrow valid from this cycle on
//  difference  out  WIDTH  result a - b - bin (mod 2^WIDTH); held until next acceptance
//  barrow      out  1      final borrow-out (1 when a < b + bin, unsigned)
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE, busy=0, done=0, difference=0, barrow=0, digit count=0, borrow reg=0.
//  - FSM states: IDLE, RUN, DONE.
//    IDLE: start=1 -> latch a, b, bin; clear count; borrow reg<=bin; -> RUN.
//    RUN: each cycle subtract digit[count] of a and b with borrow reg; write result digit into difference[count*DIGIT +: DIGIT];
//         borrow reg <= digit borrow-out; count++. On last digit (count==WIDTH/DIGIT-1) -> DONE.
//    DONE: done=1, barrow=borrow reg, busy=0. start=1 in this cycle is accepted (-> RUN, new operands latched); else -> IDLE.
//  - Latency: accepted start at edge N -> done high during cycle N+WIDTH/DIGIT+1; throughput one op per WIDTH/DIGIT+1 cycles.
//  - busy=1 exactly while in RUN. start while busy is ignored (no queuing, no error).
//  - difference and barrow are not changed on acceptance; difference is overwritten digit-by-digit during RUN and only valid once done.
//  - Per-bit arithmetic: d = x ^ y ^ bi; bo = (~x & y) | (~(x ^ y) & bi), rippled LSB->MSB inside a digit.
//  - WIDTH==DIGIT: single RUN cycle. Counter width = clog2(WIDTH/DIGIT), minimum 1 bit.
//  - Reset mid-operation aborts: state->IDLE, outputs cleared, partial result discarded, no done pulse.
//  - Operand inputs may change freely after acceptance; they are not sampled again.
// CONFIGURATION
//  SERIAL_SUB_OVF_EN defined: extra output ovf (1 bit, reset 0), valid with done: signed two's-complement overflow =
//    borrow into MSB ^ borrow out of MSB, captured on the last RUN digit and held until the next acceptance.
//  SERIAL_SUB_OVF_EN undefined: no ovf port, no MSB-borrow capture logic; all else identical.
// STRUCTURE
//  - Shared package/include serial_sub_pkg: state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
//    Parameter checks (WIDTH % DIGIT == 0) are also kept there as a reusable macro.
//  - Sub-module fs_digit #(DIGIT): combinational DIGIT-bit ripple-borrow subtractor
//    (x, y, bi -> d, bo, plus msb_bi for overflow).
//  - Top level: FSM, digit counter, operand/result registers, borrow register.
// TESTING (WIDTH=16, DIGIT=4 unless noted)
//  1. a=16'h1234, b=16'h0234, bin=0, start 1 cycle -> busy for 4 cycles, done next, difference=16'h1000, barrow=0.
//  2. a=16'h0000, b=16'h0001, bin=0 -> difference=16'hFFFF, barrow=1; a=16'h0005, b=16'h0005, bin=1 -> 16'hFFFF, barrow=1.
//  3. SERIAL_SUB_OVF_EN: a=16'h8000, b=16'h0001 -> difference=16'h7FFF, ovf=1, barrow=0; a=16'h0003, b=16'h0001 -> ovf=0.
//  4. start pulsed during RUN with different operands -> ignored, first result unchanged;
//     start held high during DONE -> back-to-back op, second done exactly 5 cycles after first.
//  5. rst asserted after 2 RUN cycles -> immediately busy=0, done=0, difference=0, barrow=0; no done pulse follows.
//  6. WIDTH=1, DIGIT=1: all 8 (a,b,bin) combos -> difference/barrow match the fs truth table; WIDTH=8, DIGIT=1 random vs a-b-bin model.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the digit-serial subtractor.
//   serial_sub_pkg          : FSM state encoding and counter sizing helper.
//   SERIAL_SUB_CHECK_PARAMS : elaboration-time WIDTH/DIGIT legality check,
//                             expanded as a generate item inside a module.
// Optional feature macro used by the block: SERIAL_SUB_OVF_EN.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Digit counter width: enough to index every digit, never less than 1 bit.
  function automatic int cnt_width(input int ndig);
    return (ndig > 1) ? $clog2(ndig) : 1;
  endfunction

endpackage

`ifndef SERIAL_SUB_CHECK_PARAMS
`define SERIAL_SUB_CHECK_PARAMS(W, D) \
  if (((W) < 1) || ((D) < 1) || ((D) > (W)) || (((W) % (D)) != 0)) begin : g_param_check \
    $error("serial_subtractor: DIGIT must divide WIDTH and 1 <= DIGIT <= WIDTH"); \
  end
`endif

// File: rtl/serial_subtractor_if.sv
// Handshake/data bundle between a requesting controller and serial_subtractor.
//   start, a, b, bin             : request side (master drives)
//   busy, done, difference,
//   barrow                       : result side (slave drives)
//   ovf                          : only present when SERIAL_SUB_OVF_EN is defined
interface serial_subtractor_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] difference;
  logic             barrow;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;

  modport master (output start, a, b, bin,
                  input  busy, done, difference, barrow, ovf);
  modport slave  (input  start, a, b, bin,
                  output busy, done, difference, barrow, ovf);
`else
  modport master (output start, a, b, bin,
                  input  busy, done, difference, barrow);
  modport slave  (input  start, a, b, bin,
                  output busy, done, difference, barrow);
`endif
endinterface

// File: rtl/serial_subtractor_fs_digit.sv
// fs_digit: combinational DIGIT-bit ripple-borrow subtractor, d = x - y - bi.
//   x, y   : digit operands
//   bi     : borrow into the LSB
//   d      : difference digit
//   bo     : borrow out of the MSB
//   msb_bi : borrow into the MSB (only with SERIAL_SUB_OVF_EN, for signed overflow)
module fs_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             bi,
  output logic [DIGIT-1:0] d,
  output logic             bo
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             msb_bi
`endif
);

  // br[i] is the borrow into bit i; br[DIGIT] leaves the digit.
  logic [DIGIT:0] br;

  always_comb begin
    br    = '0;
    d     = '0;
    br[0] = bi;
    for (int i = 0; i < DIGIT; i++) begin
      d[i]    = x[i] ^ y[i] ^ br[i];
      br[i+1] = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & br[i]);
    end
  end

  assign bo = br[DIGIT];
`ifdef SERIAL_SUB_OVF_EN
  assign msb_bi = br[DIGIT-1];
`endif

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: digit-serial subtractor, difference = a - b - bin over
// WIDTH bits, DIGIT bits per clock, borrow carried in a register between digits.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : serial_subtractor_if slave (start/a/b/bin in; busy/done/difference/barrow out)
// Optional: SERIAL_SUB_OVF_EN adds bus.ovf, signed overflow of the final result.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one digit subtracted per cycle, LSB digit first
// DONE  | one-cycle done pulse; a new start is accepted here too
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  serial_subtractor_if.slave bus
);

  localparam int            NDIG = WIDTH / DIGIT;
  localparam int            CW   = cnt_width(NDIG);
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  `SERIAL_SUB_CHECK_PARAMS(WIDTH, DIGIT)

  state_t           state, state_nxt;
  logic             accept;
  logic             last;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             borrow_r;
  logic [WIDTH-1:0] diff_r;
  logic             barrow_r;
  logic [DIGIT-1:0] x_dig;
  logic [DIGIT-1:0] y_dig;
  logic [DIGIT-1:0] d_dig;
  logic             bo_dig;
`ifdef SERIAL_SUB_OVF_EN
  logic             msb_bi_dig;
  logic             ovf_r;
`endif

  assign last  = (cnt == LAST);
  assign x_dig = a_r[cnt*DIGIT +: DIGIT];
  assign y_dig = b_r[cnt*DIGIT +: DIGIT];

  fs_digit #(
    .DIGIT (DIGIT)
  ) u_fs_digit (
    .x      (x_dig),
    .y      (y_dig),
    .bi     (borrow_r),
    .d      (d_dig),
    .bo     (bo_dig)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .msb_bi (msb_bi_dig)
`endif
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Results (diff_r, barrow_r) are left alone on acceptance; the previous
  // answer stays visible until RUN starts overwriting digits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      a_r      <= '0;
      b_r      <= '0;
      borrow_r <= 1'b0;
      diff_r   <= '0;
      barrow_r <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_r    <= 1'b0;
`endif
    end else if (accept) begin
      cnt      <= '0;
      a_r      <= bus.a;
      b_r      <= bus.b;
      borrow_r <= bus.bin;
    end else if (state == RUN) begin
      diff_r[cnt*DIGIT +: DIGIT] <= d_dig;
      borrow_r                   <= bo_dig;
      if (last) begin
        cnt      <= '0;
        barrow_r <= bo_dig;
`ifdef SERIAL_SUB_OVF_EN
        ovf_r    <= msb_bi_dig ^ bo_dig;
`endif
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign bus.busy       = (state == RUN);
  assign bus.done       = (state == DONE);
  assign bus.difference = diff_r;
  assign bus.barrow     = barrow_r;
`ifdef SERIAL_SUB_OVF_EN
  assign bus.ovf        = ovf_r;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: three instances
// (16/4, 8/1, 1/1) checked against an arithmetic model of a - b - bin.
// Overflow checks are included when SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  serial_subtractor_if #(.WIDTH(16)) i16 ();
  serial_subtractor_if #(.WIDTH(8))  i8  ();
  serial_subtractor_if #(.WIDTH(1))  i1  ();

  serial_subtractor #(.WIDTH(16), .DIGIT(4)) u16 (.clk(clk), .rst(rst), .bus(i16.slave));
  serial_subtractor #(.WIDTH(8),  .DIGIT(1)) u8  (.clk(clk), .rst(rst), .bus(i8.slave));
  serial_subtractor #(.WIDTH(1),  .DIGIT(1)) u1  (.clk(clk), .rst(rst), .bus(i1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int width_of(input int sel);
    case (sel)
      0:       return 16;
      1:       return 8;
      default: return 1;
    endcase
  endfunction

  function automatic int ndig_of(input int sel);
    case (sel)
      0:       return 4;
      1:       return 8;
      default: return 1;
    endcase
  endfunction

  function automatic logic f_done(input int sel);
    case (sel)
      0:       return i16.done;
      1:       return i8.done;
      default: return i1.done;
    endcase
  endfunction

  function automatic logic f_busy(input int sel);
    case (sel)
      0:       return i16.busy;
      1:       return i8.busy;
      default: return i1.busy;
    endcase
  endfunction

  function automatic logic [15:0] f_diff(input int sel);
    case (sel)
      0:       return i16.difference;
      1:       return {8'h00, i8.difference};
      default: return {15'h0000, i1.difference};
    endcase
  endfunction

  function automatic logic f_bo(input int sel);
    case (sel)
      0:       return i16.barrow;
      1:       return i8.barrow;
      default: return i1.barrow;
    endcase
  endfunction

  // Reference: {ovf, borrow, diff} from integer arithmetic on w-bit operands.
  function automatic logic [17:0] model(input int w, input logic [15:0] a,
                                        input logic [15:0] b, input logic bin);
    longint full, half, mask, ua, ub, ubin, sa, sb, sr;
    logic [15:0] d;
    logic        bo, ov;
    full = longint'(1) << w;
    half = full / 2;
    mask = full - 1;
    ua   = longint'(a) & mask;
    ub   = longint'(b) & mask;
    ubin = bin ? 1 : 0;
    d    = 16'((ua - ub - ubin) & mask);
    bo   = (ua < ub + ubin);
    sa   = (ua >= half) ? ua - full : ua;
    sb   = (ub >= half) ? ub - full : ub;
    sr   = sa - sb - ubin;
    ov   = (sr > half - 1) || (sr < -half);
    return {ov, bo, d};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic st, input logic [15:0] a,
                       input logic [15:0] b, input logic bin);
    case (sel)
      0: begin i16.start = st; i16.a = a;      i16.b = b;      i16.bin = bin; end
      1: begin i8.start  = st; i8.a  = a[7:0]; i8.b  = b[7:0]; i8.bin  = bin; end
      default: begin i1.start = st; i1.a = a[0]; i1.b = b[0]; i1.bin = bin; end
    endcase
  endtask

  task automatic check_result(input int sel, input string tag, input logic [15:0] a,
                              input logic [15:0] b, input logic bin);
    logic [17:0] m;
    m = model(width_of(sel), a, b, bin);
    check({tag, "_diff"},   32'(f_diff(sel)), 32'(m[15:0]));
    check({tag, "_barrow"}, 32'(f_bo(sel)),   32'(m[16]));
`ifdef SERIAL_SUB_OVF_EN
    if (sel == 0) check({tag, "_ovf"}, 32'(i16.ovf), 32'(m[17]));
`endif
  endtask

  // One full operation: request, scramble inputs after acceptance, wait for done.
  task automatic run_op(input int sel, input logic [15:0] a, input logic [15:0] b,
                        input logic bin, input string tag);
    int busy_cycles;
    int waited;
    @(posedge clk); #1;
    drive(sel, 1'b1, a, b, bin);
    @(posedge clk); #1;
    drive(sel, 1'b0, 16'($urandom), 16'($urandom), 1'($urandom));
    busy_cycles = 0;
    waited      = 0;
    while (!f_done(sel) && waited < 200) begin
      if (f_busy(sel)) busy_cycles++;
      @(posedge clk); #1;
      waited++;
    end
    check({tag, "_done_seen"},   32'(f_done(sel)), 32'd1);
    check({tag, "_busy_cycles"}, 32'(busy_cycles), 32'(ndig_of(sel)));
    check({tag, "_busy_at_done"}, 32'(f_busy(sel)), 32'd0);
    check_result(sel, tag, a, b, bin);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 32'(f_done(sel)), 32'd0);
    check_result(sel, {tag, "_held"}, a, b, bin);
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic        rbin;
    int          waited;
    int          gap;
    int          done_cnt;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    drive(0, 1'b0, 16'h0, 16'h0, 1'b0);
    drive(1, 1'b0, 16'h0, 16'h0, 1'b0);
    drive(2, 1'b0, 16'h0, 16'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int s = 0; s < 3; s++) begin
      check($sformatf("reset_busy_%0d", s),   32'(f_busy(s)), 32'd0);
      check($sformatf("reset_done_%0d", s),   32'(f_done(s)), 32'd0);
      check($sformatf("reset_diff_%0d", s),   32'(f_diff(s)), 32'd0);
      check($sformatf("reset_barrow_%0d", s), 32'(f_bo(s)),   32'd0);
    end
`ifdef SERIAL_SUB_OVF_EN
    check("reset_ovf", 32'(i16.ovf), 32'd0);
`endif

    run_op(0, 16'h1234, 16'h0234, 1'b0, "t1");
    check("t1_const", 32'(i16.difference), 32'h1000);
    run_op(0, 16'h0000, 16'h0001, 1'b0, "t2a");
    run_op(0, 16'h0005, 16'h0005, 1'b1, "t2b");
    check("t2b_const", 32'(i16.difference), 32'hFFFF);
    run_op(0, 16'h8000, 16'h0001, 1'b0, "t3a");
    run_op(0, 16'h0003, 16'h0001, 1'b0, "t3b");
    run_op(0, 16'h7FFF, 16'hFFFF, 1'b1, "t3c");

    // Start pulsed mid-RUN with other operands must not disturb the result.
    @(posedge clk); #1;
    drive(0, 1'b1, 16'hA5A5, 16'h1234, 1'b1);
    @(posedge clk); #1;
    drive(0, 1'b0, 16'h0, 16'h0, 1'b0);
    @(posedge clk); #1;
    drive(0, 1'b1, 16'hFFFF, 16'h0001, 1'b0);
    @(posedge clk); #1;
    drive(0, 1'b0, 16'h0, 16'h0, 1'b0);
    waited = 0;
    while (!i16.done && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    check("t4_ignore_done", 32'(i16.done), 32'd1);
    check_result(0, "t4_ignore", 16'hA5A5, 16'h1234, 1'b1);
    @(posedge clk); #1;
    check("t4_ignore_idle", 32'(i16.busy), 32'd0);

    // Back-to-back: start held through DONE launches the second op at once.
    drive(0, 1'b1, 16'h4321, 16'h1111, 1'b0);
    @(posedge clk); #1;
    drive(0, 1'b0, 16'h0, 16'h0, 1'b0);
    waited = 0;
    while (!i16.done && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    check_result(0, "t4_b2b_first", 16'h4321, 16'h1111, 1'b0);
    drive(0, 1'b1, 16'h0100, 16'h0200, 1'b1);
    @(posedge clk); #1;
    drive(0, 1'b0, 16'h0, 16'h0, 1'b0);
    gap = 1;
    while (!i16.done && gap < 50) begin
      @(posedge clk); #1;
      gap++;
    end
    check("t4_b2b_gap", 32'(gap), 32'd5);
    check_result(0, "t4_b2b_second", 16'h0100, 16'h0200, 1'b1);

    // Reset after two RUN cycles aborts the operation.
    @(posedge clk); #1;
    drive(0, 1'b1, 16'hF0F0, 16'h0F0F, 1'b0);
    @(posedge clk); #1;
    drive(0, 1'b0, 16'h0, 16'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("t5_busy",   32'(i16.busy),       32'd0);
    check("t5_done",   32'(i16.done),       32'd0);
    check("t5_diff",   32'(i16.difference), 32'd0);
    check("t5_barrow", 32'(i16.barrow),     32'd0);
    @(posedge clk); #1;
    rst      = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (i16.done) done_cnt++;
    end
    check("t5_no_done", 32'(done_cnt), 32'd0);

    for (int i = 0; i < 8; i++) begin
      ra   = {15'h0, 1'(i >> 2)};
      rb   = {15'h0, 1'(i >> 1)};
      rbin = 1'(i);
      run_op(2, ra, rb, rbin, $sformatf("t6_w1_%0d", i));
    end
    for (int i = 0; i < 16; i++) begin
      ra   = 16'($urandom);
      rb   = 16'($urandom);
      rbin = 1'($urandom);
      run_op(1, ra, rb, rbin, $sformatf("t6_w8_%0d", i));
    end
    for (int i = 0; i < 16; i++) begin
      ra   = 16'($urandom);
      rb   = 16'($urandom);
      rbin = 1'($urandom);
      run_op(0, ra, rb, rbin, $sformatf("rnd16_%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
